mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: controller states, memory
// geometry and the instruction word presented while the CPU is held.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int IMEM_W = 16;
  localparam int DMEM_W = 8;
  localparam int LDCNT_W = ADDR_W + 1;
  localparam int STCNT_W = 16;

  // MOVA R0,R0 encodes as all zeros.
  localparam logic [IMEM_W-1:0] NOP_ENC = 16'h0000;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Generic single-write-port RAM with asynchronous read; contents are never reset.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Program/data memory front end for a small CPU: optional data clear, host
// load phase, then CPU run with fetch, load and store ports.
module mem_responder
  import mem_pkg::*;
#(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] NOP_WORD       = NOP_ENC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  PC,
  output logic [15:0] IR,
  input  logic [7:0]  Address_out,
  input  logic [7:0]  Data_out,
  input  logic        MW,
  output logic [7:0]  Data_in,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_go,
  output logic        cpu_hold,
  output logic [8:0]  ld_count,
  output logic [15:0] st_count
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
  localparam logic [LDCNT_W-1:0] LD_SAT = LDCNT_W'(DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [LDCNT_W-1:0]   ld_count_q, ld_count_d;
  logic [STCNT_W-1:0]   st_count_q, st_count_d;

  logic                 imem_we;
  logic [IMEM_W-1:0]    imem_rdata;
  logic                 dmem_we;
  logic [ADDR_W-1:0]    dmem_waddr;
  logic [DMEM_W-1:0]    dmem_wdata;
  logic [DMEM_W-1:0]    dmem_rdata;
  logic                 beat_acc;

  assign beat_acc = (state_q == ST_LOAD) && ld_valid;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ld_count_d = ld_count_q;
    st_count_d = st_count_q;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    dmem_waddr = Address_out;
    dmem_wdata = Data_out;
    unique case (state_q)
      ST_CLEAR: begin
        dmem_we    = 1'b1;
        dmem_waddr = clr_cnt_q;
        dmem_wdata = '0;
        clr_cnt_d  = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'hFF) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A beat and ld_go in the same cycle both take effect.
        if (beat_acc) begin
          imem_we    = ~ld_sel;
          dmem_we    = ld_sel;
          dmem_waddr = ld_addr;
          dmem_wdata = ld_data[7:0];
          if (ld_count_q != LD_SAT) begin
            ld_count_d = ld_count_q + 9'd1;
          end
        end
        if (ld_go) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (MW) begin
          dmem_we    = 1'b1;
          st_count_d = st_count_q + 16'd1;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
    // Nothing presented during the reset cycle may reach either memory.
    if (reset) begin
      imem_we = 1'b0;
      dmem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      ld_count_q <= '0;
      st_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ld_count_q <= ld_count_d;
      st_count_q <= st_count_d;
    end
  end

  mem_array #(
    .DATA_W (IMEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .raddr_i (PC),
    .rdata_o (imem_rdata)
  );

  mem_array #(
    .DATA_W (DMEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .waddr_i (dmem_waddr),
    .wdata_i (dmem_wdata),
    .raddr_i (Address_out),
    .rdata_o (dmem_rdata)
  );

  assign IR       = (state_q == ST_RUN) ? imem_rdata : NOP_WORD;
  assign Data_in  = dmem_rdata;
  assign ld_ready = (state_q == ST_LOAD);
  assign cpu_hold = (state_q != ST_RUN);
  assign ld_count = ld_count_q;
  assign st_count = st_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a phase-level
// behavioural model of the clear / load / run lifecycle.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PC;
  logic [15:0] IR;
  logic [7:0]  Address_out;
  logic [7:0]  Data_out;
  logic        MW;
  logic [7:0]  Data_in;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_go;
  logic        cpu_hold;
  logic [8:0]  ld_count;
  logic [15:0] st_count;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .PC(PC), .IR(IR),
    .Address_out(Address_out), .Data_out(Data_out), .MW(MW), .Data_in(Data_in),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_go(ld_go), .cpu_hold(cpu_hold),
    .ld_count(ld_count), .st_count(st_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: remaining clear cycles, running flag, counters, memories.
  int          m_clr;
  bit          m_run;
  int          m_ldc;
  int          m_stc;
  logic [15:0] im [256];
  bit          imv [256];
  logic [7:0]  dm [256];

  function automatic void model_edge();
    if (reset) begin
      m_run = 1'b0;
      m_clr = 256;
      m_ldc = 0;
      m_stc = 0;
    end else if (m_clr > 0) begin
      dm[256 - m_clr] = 8'h00;
      m_clr--;
    end else if (!m_run) begin
      if (ld_valid) begin
        if (ld_sel) dm[ld_addr] = ld_data[7:0];
        else begin
          im[ld_addr]  = ld_data;
          imv[ld_addr] = 1'b1;
        end
        if (m_ldc < 256) m_ldc++;
      end
      if (ld_go) m_run = 1'b1;
    end else if (MW) begin
      dm[Address_out] = Data_out;
      m_stc = (m_stc + 1) % 65536;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; MW = 1'b0; ld_valid = 1'b0; ld_go = 1'b0;
    ld_sel = 1'b0; ld_addr = 8'h00; ld_data = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold: got %b want 1", cpu_hold); else n_pass++;
    n_chk++; if (ld_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ld_ready); else n_pass++;
    n_chk++; if (ld_count !== 9'd0) $display("FAIL reset_ldcnt: got %0d want 0", ld_count); else n_pass++;
    n_chk++; if (st_count !== 16'd0) $display("FAIL reset_stcnt: got %0d want 0", st_count); else n_pass++;
    n_chk++; if (IR !== 16'h0000) $display("FAIL reset_ir: got %h want 0000", IR); else n_pass++;
  endtask

  // 256 clear cycles (ld_go pulsed mid-clear must be ignored), then every dmem word reads 0.
  task automatic test_clear(input bit poke_go);
    int bad_hold = 0;
    int bad_ready = 0;
    int bad_zero = 0;
    for (int i = 1; i <= 256; i++) begin
      ld_go = poke_go && (i == 10);
      tick();
      if (cpu_hold !== 1'b1) bad_hold++;
      if (i < 256 && ld_ready !== 1'b0) bad_ready++;
    end
    ld_go = 1'b0;
    n_chk++; if (bad_hold != 0) $display("FAIL clear_hold: %0d cycles with hold low, want 0", bad_hold); else n_pass++;
    n_chk++; if (bad_ready != 0) $display("FAIL clear_ready_early: %0d early cycles, want 0", bad_ready); else n_pass++;
    n_chk++; if (ld_ready !== 1'b1) $display("FAIL clear_ready_257: got %b want 1", ld_ready); else n_pass++;
    for (int a = 0; a < 256; a++) begin
      Address_out = 8'(a);
      tick();
      if (Data_in !== 8'h00 || dm[a] !== 8'h00) bad_zero++;
    end
    n_chk++; if (bad_zero != 0) $display("FAIL clear_zero: %0d nonzero words, want 0", bad_zero); else n_pass++;
    n_chk++; if (cpu_hold !== 1'b1) $display("FAIL clear_still_held: got %b want 1", cpu_hold); else n_pass++;
  endtask

  task automatic test_load_run();
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 8'd0; ld_data = 16'h0401;
    tick();
    ld_sel = 1'b1; ld_addr = 8'd5; ld_data = 16'h00AA;
    tick();
    ld_valid = 1'b0;
    n_chk++; if (IR !== 16'h0000) $display("FAIL load_ir_nop: got %h want 0000", IR); else n_pass++;
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    PC = 8'd0; Address_out = 8'd5;
    #1;
    n_chk++; if (ld_count !== 9'(m_ldc)) $display("FAIL load_count: got %0d want %0d", ld_count, m_ldc); else n_pass++;
    n_chk++; if (cpu_hold !== 1'b0) $display("FAIL load_run_hold: got %b want 0", cpu_hold); else n_pass++;
    n_chk++; if (IR !== 16'h0401) $display("FAIL load_ir: got %h want 0401", IR); else n_pass++;
    n_chk++; if (Data_in !== 8'hAA) $display("FAIL load_dmem: got %h want AA", Data_in); else n_pass++;
  endtask

  task automatic test_store();
    logic [7:0] old_v;
    old_v = dm[8'h10];
    MW = 1'b1; Address_out = 8'h10; Data_out = 8'h3C;
    #1;
    n_chk++; if (Data_in !== old_v) $display("FAIL store_before: got %h want %h", Data_in, old_v); else n_pass++;
    tick();
    MW = 1'b0;
    #1;
    n_chk++; if (Data_in !== 8'h3C) $display("FAIL store_after: got %h want 3C", Data_in); else n_pass++;
    n_chk++; if (st_count !== 16'(m_stc)) $display("FAIL store_count: got %0d want %0d", st_count, m_stc); else n_pass++;
  endtask

  // Random CPU traffic in RUN with a narrow address window to force store/read overlap.
  task automatic test_random_run(input int cycles);
    int bad_ir = 0;
    int bad_din = 0;
    for (int c = 0; c < cycles; c++) begin
      PC = 8'($urandom_range(0, 255));
      Address_out = 8'($urandom_range(0, 15));
      Data_out = 8'($urandom);
      MW = 1'($urandom);
      #1;
      if (imv[PC] && IR !== im[PC]) bad_ir++;
      if (Data_in !== dm[Address_out]) bad_din++;
      tick();
    end
    MW = 1'b0;
    #1;
    n_chk++; if (bad_ir != 0) $display("FAIL run_ir: %0d wrong fetches, want 0", bad_ir); else n_pass++;
    n_chk++; if (bad_din != 0) $display("FAIL run_din: %0d wrong loads, want 0", bad_din); else n_pass++;
    n_chk++; if (st_count !== 16'(m_stc)) $display("FAIL run_stcnt: got %0d want %0d", st_count, m_stc); else n_pass++;
    n_chk++; if (cpu_hold !== 1'b0) $display("FAIL run_hold: got %b want 0", cpu_hold); else n_pass++;
  endtask

  task automatic test_reset_in_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (cpu_hold !== 1'b1) $display("FAIL rir_hold: got %b want 1", cpu_hold); else n_pass++;
    test_clear(1'b1);
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    PC = 8'd0;
    #1;
    n_chk++; if (IR !== im[0]) $display("FAIL rir_ir0: got %h want %h", IR, im[0]); else n_pass++;
    n_chk++; if (IR !== 16'h0401) $display("FAIL rir_ir0_const: got %h want 0401", IR); else n_pass++;
    n_chk++; if (ld_count !== 9'd0) $display("FAIL rir_ldcnt: got %0d want 0", ld_count); else n_pass++;
  endtask

  task automatic test_valid_go();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_clear(1'b0);
    // A beat presented during the reset cycle must be dropped.
    reset = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 8'd0; ld_data = 16'hFFFF;
    tick();
    idle_inputs();
    test_clear(1'b0);
    // A store while the CPU is held must not write.
    MW = 1'b1; Address_out = 8'h10; Data_out = 8'h3C;
    tick();
    MW = 1'b0;
    #1;
    n_chk++; if (Data_in !== 8'h00) $display("FAIL held_store_din: got %h want 00", Data_in); else n_pass++;
    n_chk++; if (st_count !== 16'd0) $display("FAIL held_store_cnt: got %0d want 0", st_count); else n_pass++;
    ld_valid = 1'b1; ld_go = 1'b1; ld_sel = 1'b0; ld_addr = 8'd7; ld_data = 16'hBEEF;
    tick();
    idle_inputs();
    PC = 8'd7;
    #1;
    n_chk++; if (cpu_hold !== 1'b0) $display("FAIL vg_run: got hold %b want 0", cpu_hold); else n_pass++;
    n_chk++; if (IR !== 16'hBEEF) $display("FAIL vg_ir7: got %h want BEEF", IR); else n_pass++;
    n_chk++; if (ld_count !== 9'd1) $display("FAIL vg_ldcnt: got %0d want 1", ld_count); else n_pass++;
    PC = 8'd0;
    #1;
    n_chk++; if (IR !== 16'h0401) $display("FAIL reset_beat_dropped: got %h want 0401", IR); else n_pass++;
  endtask

  task automatic test_saturate();
    int bad_cnt = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_clear(1'b0);
    ld_valid = 1'b1;
    for (int b = 0; b < 300; b++) begin
      ld_sel  = 1'($urandom);
      ld_addr = 8'($urandom);
      ld_data = 16'($urandom);
      tick();
      if (ld_count !== 9'(m_ldc)) bad_cnt++;
      if (b == 255) begin
        n_chk++; if (ld_count !== 9'd256) $display("FAIL sat_256: got %0d want 256", ld_count); else n_pass++;
      end
    end
    idle_inputs();
    n_chk++; if (bad_cnt != 0) $display("FAIL sat_track: %0d mismatching cycles, want 0", bad_cnt); else n_pass++;
    n_chk++; if (ld_count !== 9'd256) $display("FAIL sat_300: got %0d want 256", ld_count); else n_pass++;
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    test_random_run(300);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      im[i] = 16'h0000; imv[i] = 1'b0; dm[i] = 8'h00;
    end
    m_clr = 0; m_run = 1'b0; m_ldc = 0; m_stc = 0;
    PC = 8'h00; Address_out = 8'h00; Data_out = 8'h00;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_clear(1'b0);
    test_load_run();
    test_store();
    test_random_run(200);
    test_reset_in_run();
    test_valid_go();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
